// File: rtl/instruction_fetch_stage.sv
// Instruction fetch stage of the RV32IM pipeline.
//
// Holds the program counter, issues word fetches to instruction memory
// (which may stall with a busywait) and drives the IF/ID pipeline register.
// The next PC is either PC+4 or a redirect target from EX. The stage
// supports a hazard stall, a branch flush and a one-entry skid buffer.
//
// Ports:
//   CLK            in   rising-edge clock
//   RESET          in   asynchronous, active-high reset
//   STALL          in   hazard unit: hold PC and IF/ID
//   BRANCH_TAKEN   in   redirect request from EX
//   BRANCH_TARGET  in   redirect address, bits [1:0] ignored
//   IMEM_BUSYWAIT  in   instruction memory not ready
//   IMEM_READDATA  in   fetched word, valid when READ=1 and BUSYWAIT=0
//   IMEM_ADDRESS   out  fetch address (always the PC register)
//   IMEM_READ      out  fetch request
//   IFID_PC        out  PC of the instruction in IF/ID
//   IFID_PC_PLUS4  out  IFID_PC + 4
//   IFID_INSTR     out  instruction for decode
//   IFID_VALID     out  IF/ID holds a real instruction
module instruction_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        STALL,
    input  logic        BRANCH_TAKEN,
    input  logic [31:0] BRANCH_TARGET,
    input  logic        IMEM_BUSYWAIT,
    input  logic [31:0] IMEM_READDATA,
    output logic [31:0] IMEM_ADDRESS,
    output logic        IMEM_READ,
    output logic [31:0] IFID_PC,
    output logic [31:0] IFID_PC_PLUS4,
    output logic [31:0] IFID_INSTR,
    output logic        IFID_VALID
);

    // FETCH: request outstanding at PC.
    // HOLD : fetched word parked in the skid buffer while decode is stalled.
    // DRAIN: a redirect arrived mid-access; finish the access at the old PC
    //        and throw the data away before fetching the target.
    typedef enum logic [1:0] {
        S_FETCH,
        S_HOLD,
        S_DRAIN
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] skid_q, skid_d;
    logic [31:0] target_q, target_d;
    logic [31:0] ifid_pc_q, ifid_pc_d;
    logic [31:0] ifid_pc4_q, ifid_pc4_d;
    logic [31:0] ifid_instr_q, ifid_instr_d;
    logic        ifid_valid_q, ifid_valid_d;

    logic        imem_read;
    logic        done;
    logic [31:0] pc_plus4;
    logic [31:0] branch_pc;

    assign imem_read = (state_q != S_HOLD);
    assign done      = imem_read && !IMEM_BUSYWAIT;
    assign pc_plus4  = pc_q + 32'd4;      // wraps modulo 2^32
    assign branch_pc = {BRANCH_TARGET[31:2], 2'b00};

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        skid_d       = skid_q;
        target_d     = target_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_pc4_d   = ifid_pc4_q;
        ifid_instr_d = ifid_instr_q;
        ifid_valid_d = ifid_valid_q;

        if (BRANCH_TAKEN) begin
            ifid_valid_d = 1'b0;
            ifid_instr_d = NOP_INSTR;
            skid_d       = '0;
            // An access still in flight must complete before the target can
            // be fetched; a redirect seen while draining replaces the target.
            if ((state_q == S_FETCH || state_q == S_DRAIN) && IMEM_BUSYWAIT) begin
                target_d = branch_pc;
                state_d  = S_DRAIN;
            end else begin
                pc_d    = branch_pc;
                state_d = S_FETCH;
            end
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (STALL) begin
                        if (done) begin
                            skid_d  = IMEM_READDATA;
                            state_d = S_HOLD;
                        end
                    end else if (done) begin
                        ifid_pc_d    = pc_q;
                        ifid_pc4_d   = pc_plus4;
                        ifid_instr_d = IMEM_READDATA;
                        ifid_valid_d = 1'b1;
                        pc_d         = pc_plus4;
                    end else begin
                        ifid_valid_d = 1'b0;
                        ifid_instr_d = NOP_INSTR;
                    end
                end
                S_HOLD: begin
                    if (!STALL) begin
                        ifid_pc_d    = pc_q;
                        ifid_pc4_d   = pc_plus4;
                        ifid_instr_d = skid_q;
                        ifid_valid_d = 1'b1;
                        pc_d         = pc_plus4;
                        state_d      = S_FETCH;
                    end
                end
                S_DRAIN: begin
                    // IF/ID is already a bubble here, so a stall has nothing
                    // to hold; the discarded access is allowed to finish.
                    ifid_valid_d = 1'b0;
                    ifid_instr_d = NOP_INSTR;
                    if (done) begin
                        pc_d    = target_q;
                        state_d = S_FETCH;
                    end
                end
                default: begin
                    state_d = S_FETCH;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q      <= S_FETCH;
            pc_q         <= RESET_PC;
            skid_q       <= '0;
            target_q     <= '0;
            ifid_pc_q    <= '0;
            ifid_pc4_q   <= '0;
            ifid_instr_q <= NOP_INSTR;
            ifid_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            skid_q       <= skid_d;
            target_q     <= target_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_pc4_q   <= ifid_pc4_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_valid_q <= ifid_valid_d;
        end
    end

    assign IMEM_ADDRESS  = pc_q;
    assign IMEM_READ     = imem_read;
    assign IFID_PC       = ifid_pc_q;
    assign IFID_PC_PLUS4 = ifid_pc4_q;
    assign IFID_INSTR    = ifid_instr_q;
    assign IFID_VALID    = ifid_valid_q;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Scoreboard bench for instruction_fetch_stage: the stimulus process pushes
// the PC of every instruction that should reach IF/ID, and a monitor pops and
// compares each new valid IF/ID entry. A second instance with a top-of-memory
// reset PC covers address wrap-around.
module tb_instruction_fetch_stage;

    localparam logic [31:0] TAG = 32'hC0DE_0000;
    localparam logic [31:0] BAD = 32'hBAD0_BAD0;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        STALL = 1'b0;
    logic        BT = 1'b0;
    logic        BW = 1'b0;
    logic [31:0] TGT = '0;

    logic [31:0] rdata, addr, ifid_pc, ifid_pc4, ifid_instr;
    logic        read, valid;

    logic [31:0] w_rdata, w_addr, w_pc, w_pc4, w_instr;
    logic        w_read, w_valid;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_q[$];

    logic        mon_prev_valid = 1'b0;
    logic [31:0] mon_prev_pc = '0;
    logic [31:0] mon_exp;

    always #5 CLK = ~CLK;

    // Memory model: address-tagged word when a ready read is presented,
    // garbage otherwise so stale or unrequested data is visible.
    assign rdata   = (read && !BW) ? (addr ^ TAG) : BAD;
    assign w_rdata = w_read ? (w_addr ^ TAG) : BAD;

    instruction_fetch_stage dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .STALL        (STALL),
        .BRANCH_TAKEN (BT),
        .BRANCH_TARGET(TGT),
        .IMEM_BUSYWAIT(BW),
        .IMEM_READDATA(rdata),
        .IMEM_ADDRESS (addr),
        .IMEM_READ    (read),
        .IFID_PC      (ifid_pc),
        .IFID_PC_PLUS4(ifid_pc4),
        .IFID_INSTR   (ifid_instr),
        .IFID_VALID   (valid)
    );

    instruction_fetch_stage #(
        .RESET_PC (32'hFFFF_FFFC),
        .NOP_INSTR(32'h0000_0013)
    ) u_wrap (
        .CLK          (CLK),
        .RESET        (RESET),
        .STALL        (1'b0),
        .BRANCH_TAKEN (1'b0),
        .BRANCH_TARGET(32'h0),
        .IMEM_BUSYWAIT(1'b0),
        .IMEM_READDATA(w_rdata),
        .IMEM_ADDRESS (w_addr),
        .IMEM_READ    (w_read),
        .IFID_PC      (w_pc),
        .IFID_PC_PLUS4(w_pc4),
        .IFID_INSTR   (w_instr),
        .IFID_VALID   (w_valid)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    // Monitor: a new IF/ID entry is a valid one whose PC differs from the
    // previous sample (held entries during a stall are not re-counted).
    initial begin
        forever begin
            @(negedge CLK);
            if (RESET) begin
                mon_prev_valid = 1'b0;
            end else begin
                if (valid && (!mon_prev_valid || ifid_pc != mon_prev_pc)) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_instr: got pc %h expected none", ifid_pc);
                    end else begin
                        mon_exp = exp_q.pop_front();
                        chk("ifid_pc", ifid_pc, mon_exp);
                        chk("ifid_pc4", ifid_pc4, mon_exp + 32'd4);
                        chk("ifid_instr", ifid_instr, mon_exp ^ TAG);
                    end
                end
                mon_prev_valid = valid;
                mon_prev_pc    = ifid_pc;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        // Asynchronous reset, checked before any clock edge.
        #1 RESET = 1'b1;
        #2;
        chk("rst_valid", {31'b0, valid}, 32'd0);
        chk("rst_instr", ifid_instr, NOP);
        chk("rst_pc", ifid_pc, 32'h0);
        chk("rst_pc4", ifid_pc4, 32'h0);
        chk("rst_addr", addr, 32'h0);
        chk("rst_read", {31'b0, read}, 32'd1);
        chk("rst_wrap_addr", w_addr, 32'hFFFF_FFFC);
        @(posedge CLK);
        #2 RESET = 1'b0;

        // Zero-wait fetches from the first edge after release.
        exp_q.push_back(32'h0);
        cyc();
        chk("wrap_pc0", w_pc, 32'hFFFF_FFFC);
        chk("wrap_pc4_0", w_pc4, 32'h0);
        chk("wrap_instr0", w_instr, 32'hFFFF_FFFC ^ TAG);
        chk("addr_after_first", addr, 32'h4);
        exp_q.push_back(32'h4);
        cyc();
        chk("wrap_pc1", w_pc, 32'h0);
        chk("wrap_pc4_1", w_pc4, 32'h4);

        // Busywait for three edges at PC=8.
        BW = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("bw_valid", {31'b0, valid}, 32'd0);
            chk("bw_instr", ifid_instr, NOP);
            chk("bw_addr", addr, 32'h8);
        end
        BW = 1'b0;
        exp_q.push_back(32'h8);
        cyc();
        exp_q.push_back(32'hC);
        cyc();

        // Stall over a completed fetch at PC=16: word goes to the skid.
        STALL = 1'b1;
        cyc();
        chk("hold_read", {31'b0, read}, 32'd0);
        chk("hold_ifid_pc", ifid_pc, 32'hC);
        chk("hold_valid", {31'b0, valid}, 32'd1);
        cyc();
        chk("hold2_read", {31'b0, read}, 32'd0);
        chk("hold2_ifid_pc", ifid_pc, 32'hC);
        STALL = 1'b0;
        exp_q.push_back(32'h10);
        cyc();
        chk("unhold_read", {31'b0, read}, 32'd1);
        chk("unhold_addr", addr, 32'h14);

        // Redirect while the access at PC=20 is still busy.
        BW = 1'b1;
        BT = 1'b1;
        TGT = 32'h0000_0201;
        cyc();
        chk("drain_valid", {31'b0, valid}, 32'd0);
        chk("drain_addr", addr, 32'h14);
        chk("drain_read", {31'b0, read}, 32'd1);
        BT = 1'b0;
        cyc();
        chk("drain_addr2", addr, 32'h14);
        chk("drain_valid2", {31'b0, valid}, 32'd0);
        cyc();
        chk("drain_addr3", addr, 32'h14);
        BW = 1'b0;
        cyc();
        chk("drain_done_addr", addr, 32'h200);
        chk("drain_done_valid", {31'b0, valid}, 32'd0);
        exp_q.push_back(32'h200);
        cyc();

        // Redirect with memory ready; target low bits dropped.
        BT = 1'b1;
        TGT = 32'h0000_0103;
        cyc();
        chk("br_valid", {31'b0, valid}, 32'd0);
        chk("br_instr", ifid_instr, NOP);
        chk("br_addr", addr, 32'h100);
        BT = 1'b0;
        exp_q.push_back(32'h100);
        cyc();
        exp_q.push_back(32'h104);
        cyc();

        // Second redirect during DRAIN replaces the latched target.
        BW = 1'b1;
        BT = 1'b1;
        TGT = 32'h0000_0300;
        cyc();
        chk("ow_addr", addr, 32'h108);
        chk("ow_valid", {31'b0, valid}, 32'd0);
        TGT = 32'h0000_0400;
        cyc();
        chk("ow_addr2", addr, 32'h108);
        BT = 1'b0;
        BW = 1'b0;
        cyc();
        chk("ow_target_addr", addr, 32'h400);
        exp_q.push_back(32'h400);
        cyc();

        // Asynchronous reset in the middle of DRAIN.
        BW = 1'b1;
        BT = 1'b1;
        TGT = 32'h0000_0500;
        cyc();
        chk("pre_rst_addr", addr, 32'h404);
        BT = 1'b0;
        #3 RESET = 1'b1;
        #1;
        chk("arst_valid", {31'b0, valid}, 32'd0);
        chk("arst_instr", ifid_instr, NOP);
        chk("arst_pc", ifid_pc, 32'h0);
        chk("arst_pc4", ifid_pc4, 32'h0);
        chk("arst_addr", addr, 32'h0);
        chk("arst_read", {31'b0, read}, 32'd1);
        chk("arst_wrap_addr", w_addr, 32'hFFFF_FFFC);
        #2;
        BW = 1'b0;
        RESET = 1'b0;
        exp_q.push_back(32'h0);
        cyc();
        chk("rerst_wrap_pc", w_pc, 32'hFFFF_FFFC);
        exp_q.push_back(32'h4);
        cyc();
        @(negedge CLK);
        #1;
        chk("queue_drained", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
